regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the ALU/load writeback ports, plus a per-register pending scoreboard.
// Latency: a grant is combinational, and the register-file write happens 1 cycle after acceptance.
// Backpressure: only the loser of a conflict stalls; grants alternate, so neither requester waits forever.
module regfile_wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_reg,
    output logic              RegWrite,
    output logic [5:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [31:0]       pending,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [4:0] XZR = 5'd31;

    logic              last_b;     // 1 when B holds the most recent grant
    logic              accept_a;
    logic              accept_b;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              do_write;
    logic [30:0]       pend_q;
    logic [30:0]       set_vec;
    logic [30:0]       clr_vec;

    // Grant: a lone requester wins; on a conflict, the side not granted last wins. No grants while in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset_n) begin
            if (a_valid && (!b_valid || last_b)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;
    assign sel_reg  = accept_a ? a_reg  : b_reg;
    assign sel_data = accept_a ? a_data : b_data;
    // Writes to XZR complete the handshake but never reach the register file.
    assign do_write = (accept_a || accept_b) && (sel_reg != XZR);

    // Register 31 is never tracked; a shift by 31 in a 31-bit vector yields zero anyway.
    assign set_vec = (issue_valid && issue_reg != XZR) ? (31'd1 << issue_reg) : 31'd0;
    assign clr_vec = RegWrite ? (31'd1 << WriteReg[4:0]) : 31'd0;
    assign pending = {1'b0, pend_q};

    // Round-robin pointer: moves only when a request is actually accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_b <= 1'b1;
        end else if (accept_a) begin
            last_b <= 1'b0;
        end else if (accept_b) begin
            last_b <= 1'b1;
        end
    end

    // Register-file write port: the pulse lasts one cycle, while address and data hold until the next real write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= 6'd0;
            WriteData <= '0;
        end else begin
            RegWrite <= do_write;
            if (do_write) begin
                WriteReg  <= {1'b0, sel_reg};
                WriteData <= sel_data;
            end
        end
    end

    // Pending scoreboard: the clear is applied first and the set ORed after, so a same-register set wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | set_vec;
        end
    end

    // Conflict counter: counts cycles in which both sides request, and saturates rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed writeback/issue vectors; expected writes queued, monitor pops on RegWrite.
// Latency: expected writes are checked at the negedge following the accepting posedge.
// Backpressure: grants observed combinationally #1 after inputs are driven.
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clock;
    logic          reset_n;
    logic          a_valid, a_ready, b_valid, b_ready, issue_valid;
    logic [4:0]    a_reg, b_reg, issue_reg;
    logic [DW-1:0] a_data, b_data;
    logic          RegWrite;
    logic [5:0]    WriteReg;
    logic [DW-1:0] WriteData;
    logic [31:0]   pending;
    logic [CW-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;
    logic [6+DW-1:0] exp_q[$];

    regfile_wb_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RegWrite pulse must match the oldest queued expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h expected no write", WriteReg, WriteData);
            end else begin
                logic [6+DW-1:0] e;
                e = exp_q.pop_front();
                if ({WriteReg, WriteData} !== e) begin
                    errors++;
                    $display("FAIL write_port: got reg %0d data 0x%0h expected reg %0d data 0x%0h",
                             WriteReg, WriteData, e[6+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // One cycle from negedge to negedge: rw is RegWrite as seen at the start of the cycle.
    task automatic step(input logic av, input logic [4:0] ar, input logic [DW-1:0] ad,
                        input logic bv, input logic [4:0] br, input logic [DW-1:0] bd,
                        input logic iv, input logic [4:0] ir,
                        output logic ga, output logic gb, output logic rw);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        issue_valid = iv; issue_reg = ir;
        rw = RegWrite;
        #1;
        ga = a_ready;
        gb = b_ready;
        if (av && ga && ar != 5'd31) exp_q.push_back({1'b0, ar, ad});
        if (bv && gb && br != 5'd31) exp_q.push_back({1'b0, br, bd});
        @(negedge clock);
    endtask

    task automatic idle(output logic rw);
        logic ga, gb;
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0, ga, gb, rw);
    endtask

    task automatic issue(input logic [4:0] r);
        logic ga, gb, rw;
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, r, ga, gb, rw);
    endtask

    task automatic wr_a(input logic [4:0] r, input logic [DW-1:0] d);
        logic ga, gb, rw;
        step(1'b1, r, d, 1'b0, 5'd0, '0, 1'b0, 5'd0, ga, gb, rw);
        chk("wr_a_grant", {62'd0, ga, gb}, 64'h2);
    endtask

    logic ga, gb, rw;
    logic exp_a;

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b1; a_reg = 5'd1; a_data = '0;
        b_valid = 1'b1; b_reg = 5'd2; b_data = '0;
        issue_valid = 1'b1; issue_reg = 5'd3;
        #1;
        chk("rst_ready", {62'd0, a_ready, b_ready}, 64'h0);
        @(negedge clock);
        chk("rst_regwrite", {63'd0, RegWrite}, 64'h0);
        chk("rst_writereg", {58'd0, WriteReg}, 64'h0);
        chk("rst_writedata", WriteData, 64'h0);
        chk("rst_pending", {32'd0, pending}, 64'h0);
        chk("rst_conflict", {48'd0, conflict_cnt}, 64'h0);
        a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        // Four back-to-back conflicts straight after reset: A,B,A,B with writes on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB2, 1'b0, 5'd0, ga, gb, rw);
            chk($sformatf("rr_grant_%0d", i), {62'd0, ga, gb}, (i % 2 == 0) ? 64'h2 : 64'h1);
            chk($sformatf("rr_regwrite_%0d", i), {63'd0, rw}, (i == 0) ? 64'h0 : 64'h1);
        end
        chk("rr_conflict_cnt", {48'd0, conflict_cnt}, 64'd4);
        idle(rw);
        chk("rr_regwrite_4", {63'd0, rw}, 64'h1);

        // Lone A request is granted immediately and written one cycle later.
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0, ga, gb, rw);
        chk("solo_a_grant", {62'd0, ga, gb}, 64'h2);
        chk("solo_a_prev_idle", {63'd0, rw}, 64'h0);
        idle(rw);
        chk("solo_a_regwrite", {63'd0, rw}, 64'h1);
        chk("hold_regwrite", {63'd0, RegWrite}, 64'h0);
        chk("hold_writereg", {58'd0, WriteReg}, 64'd5);
        chk("hold_writedata", WriteData, 64'h1234);

        // XZR write handshakes but does not write or touch pending.
        issue(5'd7);
        chk("issue7_pending", {32'd0, pending}, 64'h80);
        step(1'b0, 5'd0, '0, 1'b1, 5'd31, 64'hDEAD, 1'b0, 5'd0, ga, gb, rw);
        chk("xzr_grant", {62'd0, ga, gb}, 64'h1);
        chk("xzr_regwrite", {63'd0, RegWrite}, 64'h0);
        chk("xzr_pending", {32'd0, pending}, 64'h80);
        chk("xzr_writereg_hold", {58'd0, WriteReg}, 64'd5);

        // Set and clear of reg 7 on the same edge: the set wins.
        wr_a(5'd7, 64'h77);
        issue(5'd7);
        chk("set_wins_pending", {32'd0, pending}, 64'h80);
        // Clear 7 while setting 9 on the same edge: both take effect.
        wr_a(5'd7, 64'h78);
        issue(5'd9);
        chk("set_clr_diff", {32'd0, pending}, 64'h200);
        issue(5'd31);
        chk("issue31_ignored", {32'd0, pending}, 64'h200);
        wr_a(5'd9, 64'h99);
        idle(rw);
        chk("clear9_pending", {32'd0, pending}, 64'h0);
        issue(5'd9);
        issue(5'd9);
        wr_a(5'd4, 64'h44);
        idle(rw);
        chk("noop_set_clr", {32'd0, pending}, 64'h200);

        // Accept an A request, then reset before the write edge: the write is lost.
        a_valid = 1'b1; a_reg = 5'd3; a_data = 64'h33;
        b_valid = 1'b0; issue_valid = 1'b0;
        #1;
        chk("pre_reset_grant", {63'd0, a_ready}, 64'h1);
        #2;
        reset_n = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("mid_reset_pending", {32'd0, pending}, 64'h0);
        @(negedge clock);
        chk("mid_reset_regwrite", {63'd0, RegWrite}, 64'h0);
        chk("mid_reset_conflict", {48'd0, conflict_cnt}, 64'h0);
        reset_n = 1'b1;
        idle(rw);
        chk("post_reset_regwrite0", {63'd0, rw}, 64'h0);
        step(1'b1, 5'd10, 64'hAA, 1'b1, 5'd11, 64'hBB, 1'b0, 5'd0, ga, gb, rw);
        chk("post_reset_regwrite1", {63'd0, rw}, 64'h0);
        chk("post_reset_grant_a", {62'd0, ga, gb}, 64'h2);

        // Saturation: the counter starts at 1 here; 2^16+3 further conflicts must stick at all-ones.
        // Grants must keep alternating, starting with B since A took the previous conflict.
        exp_a = 1'b0;
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step(1'b1, 5'd12, 64'(i), 1'b1, 5'd13, 64'(i + 1), 1'b0, 5'd0, ga, gb, rw);
            if (ga !== exp_a || gb !== !exp_a) begin
                chk("sat_alternation", {62'd0, ga, gb}, exp_a ? 64'h2 : 64'h1);
            end
            exp_a = !exp_a;
        end
        chk("sat_conflict", {48'd0, conflict_cnt}, 64'hFFFF);
        step(1'b1, 5'd12, 64'h1, 1'b1, 5'd13, 64'h2, 1'b0, 5'd0, ga, gb, rw);
        chk("sat_hold", {48'd0, conflict_cnt}, 64'hFFFF);
        idle(rw);
        idle(rw);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
